seg_scan_decoder: RTL

Receiver for the multiplexed two-digit seven-segment scan bus (active-low digit enables plus active-low abcdefgh segments). It samples the scan lines, determines which digit is being driven, and requires each pattern to hold steady before accepting it. It then decodes the pattern back to BCD and reports the units and tens digits, with per-digit valid, staleness timeout and error flags. It sits on the board-monitor/self-test side, attached to the same nets that drive the display.

---
 rtl/seg_scan_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Monitors a multiplexed two-digit seven-segment scan bus (active-low digit
// enables, active-low abcdefgh segments), waits for each (enable, segment)
// pair to hold steady, then decodes it back to BCD for the units/tens digit.
// Each digit carries a valid flag that clears on blank/bad patterns or when
// no commit has reached that digit for TIMEOUT_CYCLES cycles.
//
// Build option: SEG_SCAN_GLITCH_FILTER_EN
//   defined   -> a pair must be stable for STABLE_CYCLES before it commits
//   undefined -> no filter; behaves as STABLE_CYCLES = 1
//
// state | meaning
// IDLE  | no digit selected on the bus
// TRACK | a digit is selected, waiting for the pair to settle
// HELD  | current pair already committed, waiting for it to change
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] illuminate,
  input  logic [7:0] segment,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       units_valid,
  output logic       tens_valid,
  output logic       update,
  output logic       bad_pattern
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t state_q, state_d;

  logic [7:0] ill_s1_q, ill_s2_q, ill_p_q;
  logic [7:0] seg_s1_q, seg_s2_q, seg_p_q;

  logic          sel_units, sel_tens, sel_any, changed, stable_done;
  logic          commit, is_digit, is_blank;
  logic [3:0]    dec_val;

  logic [3:0]    units_q, units_d, tens_q, tens_d;
  logic          uv_q, uv_d, tv_q, tv_d;
  logic          update_q, update_d, bad_q, bad_d;
  logic [TW-1:0] u_tmo_q, u_tmo_d, t_tmo_q, t_tmo_d;

  // Two-flop synchronizer plus a copy of the previous synchronized pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ill_s1_q <= 8'hFF;
      ill_s2_q <= 8'hFF;
      ill_p_q  <= 8'hFF;
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      seg_p_q  <= 8'hFF;
    end else begin
      ill_s1_q <= illuminate;
      ill_s2_q <= ill_s1_q;
      ill_p_q  <= ill_s2_q;
      seg_s1_q <= segment;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
    end
  end

  assign sel_units = (ill_s2_q == 8'hFE);
  assign sel_tens  = (ill_s2_q == 8'hFD);
  assign sel_any   = sel_units | sel_tens;
  assign changed   = (ill_s2_q != ill_p_q) || (seg_s2_q != seg_p_q);

`ifdef SEG_SCAN_GLITCH_FILTER_EN
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Stability counter: restarts on any change or loss of select, saturates at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (changed || !sel_any) cnt_d = '0;
    else if (cnt_q != CNT_TOP) cnt_d = cnt_q + 1'b1;
  end

  // Stability counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stable_done = (cnt_q == CNT_TOP);
`else
  assign stable_done = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (sel_any) state_d = TRACK;
      TRACK: begin
        if (!sel_any)                     state_d = IDLE;
        else if (!changed && stable_done) state_d = HELD;
      end
      HELD: begin
        if (!sel_any)     state_d = IDLE;
        else if (changed) state_d = TRACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: commit strobe and pattern classification.
  always_comb begin
    commit   = (state_q == TRACK) && sel_any && !changed && stable_done;
    is_digit = 1'b1;
    is_blank = 1'b0;
    dec_val  = 4'd0;
    case (seg_s2_q[7:1])
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      7'b1111111: begin is_digit = 1'b0; is_blank = 1'b1; end
      default:    is_digit = 1'b0;
    endcase
  end

  // Digit registers, timeouts and pulses; a commit overrides a same-cycle timeout.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    uv_d    = uv_q;
    tv_d    = tv_q;
    u_tmo_d = (u_tmo_q == TMO_MAX) ? u_tmo_q : u_tmo_q + 1'b1;
    t_tmo_d = (t_tmo_q == TMO_MAX) ? t_tmo_q : t_tmo_q + 1'b1;
    if (u_tmo_q != TMO_MAX && u_tmo_d == TMO_MAX) uv_d = 1'b0;
    if (t_tmo_q != TMO_MAX && t_tmo_d == TMO_MAX) tv_d = 1'b0;
    if (commit && sel_units) begin
      u_tmo_d = '0;
      uv_d    = is_digit;
      if (is_digit) units_d = dec_val;
    end
    if (commit && sel_tens) begin
      t_tmo_d = '0;
      tv_d    = is_digit;
      if (is_digit) tens_d = dec_val;
    end
    bad_d    = commit && !is_digit && !is_blank;
    update_d = (units_d != units_q) || (tens_d != tens_q) ||
               (uv_d != uv_q) || (tv_d != tv_q);
  end

  // Output and timeout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units_q  <= 4'd0;
      tens_q   <= 4'd0;
      uv_q     <= 1'b0;
      tv_q     <= 1'b0;
      u_tmo_q  <= '0;
      t_tmo_q  <= '0;
      update_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      units_q  <= units_d;
      tens_q   <= tens_d;
      uv_q     <= uv_d;
      tv_q     <= tv_d;
      u_tmo_q  <= u_tmo_d;
      t_tmo_q  <= t_tmo_d;
      update_q <= update_d;
      bad_q    <= bad_d;
    end
  end

  assign units       = units_q;
  assign tens        = tens_q;
  assign units_valid = uv_q;
  assign tens_valid  = tv_q;
  assign update      = update_q;
  assign bad_pattern = bad_q;

endmodule
